// File: rtl/dsi_pkt_pkg.sv
// Shared types, constants and helpers for the DSI receive packet parser.
package dsi_pkt_pkg;

    typedef enum logic [2:0] {
        StSync,
        StDi,
        StWc0,
        StWc1,
        StEcc,
        StPayload,
        StCrc0,
        StCrc1
    } state_e;

    localparam logic [15:0] CRC_INIT = 16'hFFFF;
    localparam logic [15:0] CRC_POLY = 16'h8408;

    localparam int unsigned NUM_LONG_DT = 10;
    localparam logic [5:0] LONG_DT [NUM_LONG_DT] = '{
        6'h09, 6'h19, 6'h29, 6'h39, 6'h0C, 6'h0D, 6'h0E, 6'h1E, 6'h2E, 6'h3E
    };

    function automatic logic is_long_dt(input logic [5:0] dt);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < NUM_LONG_DT; i++) begin
            if (dt == LONG_DT[i]) hit = 1'b1;
        end
        return hit;
    endfunction

    // Reflected CRC-16, byte consumed LSB first.
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
        logic [15:0] c;
        logic        fb;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            fb = c[0] ^ data[i];
            c  = c >> 1;
            if (fb) c = c ^ CRC_POLY;
        end
        return c;
    endfunction

endpackage

// File: rtl/dsi_ecc_calc.sv
// DSI header ECC generator: 6-bit Hamming parity over {WC_MSB, WC_LSB, DI}, bit 0 = DI[0].
module dsi_ecc_calc (
    input  logic [23:0] hdr_i,
    output logic [7:0]  ecc_o
);

    logic [23:0] h;
    assign h = hdr_i;

    assign ecc_o[0] = ^{h[0], h[1], h[2], h[4], h[5], h[7], h[10], h[11], h[13], h[16],
                        h[20], h[21], h[22], h[23]};
    assign ecc_o[1] = ^{h[0], h[1], h[3], h[4], h[6], h[8], h[10], h[12], h[14], h[17],
                        h[20], h[21], h[22], h[23]};
    assign ecc_o[2] = ^{h[0], h[2], h[3], h[5], h[6], h[9], h[11], h[12], h[15], h[18],
                        h[20], h[21], h[22]};
    assign ecc_o[3] = ^{h[1], h[2], h[3], h[7], h[8], h[9], h[13], h[14], h[15], h[19],
                        h[20], h[21], h[23]};
    assign ecc_o[4] = ^{h[4], h[5], h[6], h[7], h[8], h[9], h[16], h[17], h[18], h[19],
                        h[20], h[22], h[23]};
    assign ecc_o[5] = ^{h[10], h[11], h[12], h[13], h[14], h[15], h[16], h[17], h[18], h[19],
                        h[21], h[22], h[23]};
    assign ecc_o[7:6] = 2'b00;

endmodule

// File: rtl/dsi_depacketizer.sv
// Receive-side DSI packet parser: header/ECC check, payload streaming, CRC-16 check.
module dsi_depacketizer
    import dsi_pkt_pkg::*;
#(
    parameter int unsigned MAX_WC = 4096
) (
    input  logic        dsi_clk_i,
    input  logic        dsi_rst_n_i,
    input  logic        rx_valid_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_sot_i,
    output logic        hdr_valid_o,
    output logic [7:0]  hdr_di_o,
    output logic [15:0] hdr_wc_o,
    output logic        hdr_long_o,
    output logic        ecc_err_o,
    output logic        pl_valid_o,
    output logic [7:0]  pl_data_o,
    output logic        pl_last_o,
    output logic        pkt_done_o,
    output logic        crc_err_o,
    output logic        len_err_o
);

    localparam logic [16:0] MaxWc = 17'(MAX_WC);

    state_e      state_q;
    logic [7:0]  di_q;
    logic [15:0] wc_q;
    logic [15:0] cnt_q;
    logic [15:0] crc_q;
    logic [7:0]  crc_lo_q;

    logic [7:0]  ecc_calc;
    logic        ecc_ok;
    logic        is_long;
    logic        too_long;

    dsi_ecc_calc u_ecc (
        .hdr_i (wc_q[15:0] == wc_q ? {wc_q, di_q} : 24'h0),
        .ecc_o (ecc_calc)
    );

    assign ecc_ok   = (ecc_calc == rx_data_i);
    assign is_long  = is_long_dt(di_q[5:0]);
    assign too_long = ({1'b0, wc_q} > MaxWc);

    always_ff @(posedge dsi_clk_i or negedge dsi_rst_n_i) begin
        if (!dsi_rst_n_i) begin
            state_q     <= StSync;
            di_q        <= '0;
            wc_q        <= '0;
            cnt_q       <= '0;
            crc_q       <= CRC_INIT;
            crc_lo_q    <= '0;
            hdr_valid_o <= 1'b0;
            hdr_di_o    <= '0;
            hdr_wc_o    <= '0;
            hdr_long_o  <= 1'b0;
            ecc_err_o   <= 1'b0;
            pl_valid_o  <= 1'b0;
            pl_data_o   <= '0;
            pl_last_o   <= 1'b0;
            pkt_done_o  <= 1'b0;
            crc_err_o   <= 1'b0;
            len_err_o   <= 1'b0;
        end else begin
            hdr_valid_o <= 1'b0;
            pl_valid_o  <= 1'b0;
            pl_last_o   <= 1'b0;
            pkt_done_o  <= 1'b0;
            if (rx_valid_i) begin
                // A start-of-transmission byte always begins a fresh packet.
                if (rx_sot_i || state_q == StDi) begin
                    di_q    <= rx_data_i;
                    crc_q   <= CRC_INIT;
                    state_q <= StWc0;
                end else begin
                    case (state_q)
                        StSync: state_q <= StSync;
                        StWc0: begin
                            wc_q[7:0] <= rx_data_i;
                            state_q   <= StWc1;
                        end
                        StWc1: begin
                            wc_q[15:8] <= rx_data_i;
                            state_q    <= StEcc;
                        end
                        StEcc: begin
                            hdr_valid_o <= 1'b1;
                            hdr_di_o    <= di_q;
                            hdr_wc_o    <= wc_q;
                            hdr_long_o  <= is_long;
                            ecc_err_o   <= !ecc_ok;
                            cnt_q       <= wc_q;
                            if (!ecc_ok) begin
                                state_q <= StSync;
                            end else if (!is_long) begin
                                pkt_done_o <= 1'b1;
                                crc_err_o  <= 1'b0;
                                len_err_o  <= 1'b0;
                                state_q    <= StDi;
                            end else if (too_long) begin
                                pkt_done_o <= 1'b1;
                                crc_err_o  <= 1'b0;
                                len_err_o  <= 1'b1;
                                state_q    <= StSync;
                            end else if (wc_q == 16'd0) begin
                                state_q <= StCrc0;
                            end else begin
                                state_q <= StPayload;
                            end
                        end
                        StPayload: begin
                            pl_valid_o <= 1'b1;
                            pl_data_o  <= rx_data_i;
                            pl_last_o  <= (cnt_q == 16'd1);
                            crc_q      <= crc16_byte(crc_q, rx_data_i);
                            cnt_q      <= cnt_q - 16'd1;
                            if (cnt_q == 16'd1) state_q <= StCrc0;
                        end
                        StCrc0: begin
                            crc_lo_q <= rx_data_i;
                            state_q  <= StCrc1;
                        end
                        StCrc1: begin
                            pkt_done_o <= 1'b1;
                            crc_err_o  <= ({rx_data_i, crc_lo_q} != crc_q);
                            len_err_o  <= 1'b0;
                            state_q    <= StDi;
                        end
                        default: state_q <= StSync;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_dsi_depacketizer.sv
// Scoreboard bench for dsi_depacketizer: directed packets, expected strobes queued at issue time.
module tb_dsi_depacketizer;

    logic        clk;
    logic        rst_n;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_sot;
    logic        hdr_valid;
    logic [7:0]  hdr_di;
    logic [15:0] hdr_wc;
    logic        hdr_long;
    logic        ecc_err;
    logic        pl_valid;
    logic [7:0]  pl_data;
    logic        pl_last;
    logic        pkt_done;
    logic        crc_err;
    logic        len_err;

    typedef struct packed {
        logic        hv;
        logic [7:0]  di;
        logic [15:0] wc;
        logic        lng;
        logic        ecc;
        logic        pv;
        logic [7:0]  pd;
        logic        pl;
        logic        done;
        logic        crc;
        logic        len;
    } ev_t;

    ev_t exp_q[$];
    int  n_cmp = 0;
    int  n_err = 0;
    int  gap_max = 0;

    logic [39:0] all_out;
    assign all_out = {hdr_valid, hdr_di, hdr_wc, hdr_long, ecc_err, pl_valid, pl_data,
                      pl_last, pkt_done, crc_err, len_err};

    dsi_depacketizer #(
        .MAX_WC (4096)
    ) dut (
        .dsi_clk_i   (clk),
        .dsi_rst_n_i (rst_n),
        .rx_valid_i  (rx_valid),
        .rx_data_i   (rx_data),
        .rx_sot_i    (rx_sot),
        .hdr_valid_o (hdr_valid),
        .hdr_di_o    (hdr_di),
        .hdr_wc_o    (hdr_wc),
        .hdr_long_o  (hdr_long),
        .ecc_err_o   (ecc_err),
        .pl_valid_o  (pl_valid),
        .pl_data_o   (pl_data),
        .pl_last_o   (pl_last),
        .pkt_done_o  (pkt_done),
        .crc_err_o   (crc_err),
        .len_err_o   (len_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want $finish");
        $fatal(1, "watchdog expired");
    end

    // Monitor: every output strobe is matched against the head of the expectation queue.
    always @(negedge clk) begin : mon
        ev_t act;
        ev_t want;
        if (rst_n && (hdr_valid || pl_valid || pkt_done)) begin
            act = '0;
            act.hv = hdr_valid;
            if (hdr_valid) begin
                act.di  = hdr_di;
                act.wc  = hdr_wc;
                act.lng = hdr_long;
                act.ecc = ecc_err;
            end
            act.pv = pl_valid;
            if (pl_valid) begin
                act.pd = pl_data;
                act.pl = pl_last;
            end
            act.done = pkt_done;
            if (pkt_done) begin
                act.crc = crc_err;
                act.len = len_err;
            end
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_event @%0t: got %h want none", $time, act);
            end else begin
                want = exp_q.pop_front();
                if (act !== want) begin
                    n_err++;
                    $display("FAIL event @%0t: got %h want %h", $time, act, want);
                end
            end
        end
    end

    task automatic check(input string name, input logic [39:0] got, input logic [39:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic exp_hdr(input logic [7:0] di, input logic [15:0] wc, input logic lng,
                           input logic ecc, input logic done, input logic len);
        ev_t e;
        e      = '0;
        e.hv   = 1'b1;
        e.di   = di;
        e.wc   = wc;
        e.lng  = lng;
        e.ecc  = ecc;
        e.done = done;
        e.len  = len;
        exp_q.push_back(e);
    endtask

    task automatic exp_pl(input logic [7:0] d, input logic last);
        ev_t e;
        e    = '0;
        e.pv = 1'b1;
        e.pd = d;
        e.pl = last;
        exp_q.push_back(e);
    endtask

    task automatic exp_done(input logic crc);
        ev_t e;
        e      = '0;
        e.done = 1'b1;
        e.crc  = crc;
        exp_q.push_back(e);
    endtask

    task automatic send(input logic [7:0] b, input logic sot);
        int g;
        g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
        repeat (g) begin
            @(posedge clk);
            #1;
        end
        rx_valid = 1'b1;
        rx_data  = b;
        rx_sot   = sot;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_sot   = 1'b0;
    endtask

    task automatic send_hdr(input logic [7:0] di, input logic [15:0] wc, input logic [7:0] ecc,
                            input logic sot);
        send(di, sot);
        send(wc[7:0], 1'b0);
        send(wc[15:8], 1'b0);
        send(ecc, 1'b0);
    endtask

    // Long packet whose payload is 0x31, 0x32, ... (n bytes).
    task automatic long_pkt(input logic [7:0] di, input logic [15:0] wc, input logic [7:0] ecc,
                            input logic [7:0] crc_lo, input logic [7:0] crc_hi,
                            input logic want_crc_err, input logic sot);
        exp_hdr(di, wc, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < int'(wc); i++) exp_pl(8'h31 + 8'(i), i == int'(wc) - 1);
        exp_done(want_crc_err);
        send_hdr(di, wc, ecc, sot);
        for (int i = 0; i < int'(wc); i++) send(8'h31 + 8'(i), 1'b0);
        send(crc_lo, 1'b0);
        send(crc_hi, 1'b0);
    endtask

    initial begin
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = '0;
        rx_sot   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", all_out, '0);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle_after_reset", all_out, '0);

        // Bytes without rx_sot while in SYNC are dropped.
        send_hdr(8'h01, 16'h0000, 8'h07, 1'b0);

        // Good short packet: header and done together.
        exp_hdr(8'h01, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
        send_hdr(8'h01, 16'h0000, 8'h07, 1'b1);

        // Bad ECC, then trailing bytes ignored until rx_sot.
        exp_hdr(8'h01, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
        send_hdr(8'h01, 16'h0000, 8'h06, 1'b1);
        send_hdr(8'h01, 16'h0000, 8'h07, 1'b0);

        // Long packet "123456789", good and corrupted CRC.
        long_pkt(8'h39, 16'h0009, 8'h30, 8'h91, 8'h6F, 1'b0, 1'b1);
        long_pkt(8'h39, 16'h0009, 8'h30, 8'h90, 8'h6F, 1'b1, 1'b1);

        // Empty long packet.
        long_pkt(8'h39, 16'h0000, 8'h0F, 8'hFF, 8'hFF, 1'b0, 1'b1);

        // WC = MAX_WC + 1: length error, then back in SYNC.
        exp_hdr(8'h39, 16'h1001, 1'b1, 1'b0, 1'b1, 1'b1);
        send_hdr(8'h39, 16'h1001, 8'h0A, 1'b1);
        send_hdr(8'h01, 16'h0000, 8'h07, 1'b0);

        // Back-to-back packets, the second parsed from DI without rx_sot; gap-free then gapped.
        for (int pass = 0; pass < 2; pass++) begin
            gap_max = (pass == 0) ? 0 : 3;
            long_pkt(8'h39, 16'h0009, 8'h30, 8'h91, 8'h6F, 1'b0, 1'b1);
            exp_hdr(8'h01, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
            send_hdr(8'h01, 16'h0000, 8'h07, 1'b0);
        end
        gap_max = 0;

        // rx_sot mid-payload aborts without pkt_done.
        exp_hdr(8'h39, 16'h0009, 1'b1, 1'b0, 1'b0, 1'b0);
        exp_pl(8'h31, 1'b0);
        exp_pl(8'h32, 1'b0);
        exp_pl(8'h33, 1'b0);
        send_hdr(8'h39, 16'h0009, 8'h30, 1'b1);
        send(8'h31, 1'b0);
        send(8'h32, 1'b0);
        send(8'h33, 1'b0);
        exp_hdr(8'h01, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
        send_hdr(8'h01, 16'h0000, 8'h07, 1'b1);

        // Asynchronous reset mid-payload.
        exp_hdr(8'h39, 16'h0009, 1'b1, 1'b0, 1'b0, 1'b0);
        exp_pl(8'h31, 1'b0);
        exp_pl(8'h32, 1'b0);
        send_hdr(8'h39, 16'h0009, 8'h30, 1'b1);
        send(8'h31, 1'b0);
        send(8'h32, 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_mid_payload", all_out, '0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        send(8'h33, 1'b0);
        send(8'h34, 1'b0);
        send_hdr(8'h01, 16'h0000, 8'h07, 1'b0);
        @(negedge clk);
        check("no_parse_without_sot", all_out, '0);
        exp_hdr(8'h01, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
        send_hdr(8'h01, 16'h0000, 8'h07, 1'b1);

        repeat (5) @(posedge clk);
        #1;
        check("scoreboard_drained", 40'(exp_q.size()), '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dsi_depacketizer.md
# dsi_depacketizer

Receive-side DSI packet parser: takes the lane-merged byte stream, recovers short and long packets, checks header ECC and payload CRC-16, and streams payload bytes out with header and status strobes. It consumes exactly the wire format our packetizer emits, byte order DI, WC_LSB, WC_MSB, ECC, payload, CRC_LSB, CRC_MSB. It sits between the lane deserializer and the command/pixel FIFO.

## Interface
Parameters:
- MAX_WC, 4096: largest accepted long-packet word count in bytes; a larger WC is a length error.

Ports:
- dsi_clk  in  1  sole clock, all logic on its rising edge.
- dsi_rst_n  in  1  asynchronous, active-low reset.
- rx_valid  in  1  rx_data carries a byte this cycle; there is no backpressure.
- rx_data  in  8  received byte.
- rx_sot  in  1  qualified by rx_valid: this byte is the first byte of a transmission burst.
- hdr_valid  out  1  one-cycle pulse: header fields are valid.
- hdr_di  out  8  data identifier (VC[7:6], DT[5:0]).
- hdr_wc  out  16  word count, or the two short-packet data bytes {data1, data0}.
- hdr_long  out  1  packet is a long packet.
- ecc_err  out  1  qualified by hdr_valid: header ECC mismatch.
- pl_valid  out  1  payload byte valid.
- pl_data  out  8  payload byte.
- pl_last  out  1  qualified by pl_valid: final payload byte.
- pkt_done  out  1  one-cycle pulse: packet fully consumed.
- crc_err  out  1  qualified by pkt_done: CRC mismatch, long packets only.
- len_err  out  1  qualified by pkt_done: WC > MAX_WC.

## Operation
- States: SYNC, DI, WC0, WC1, ECC, PAYLOAD, CRC0, CRC1. All transitions occur only on cycles with rx_valid=1.
- SYNC: ignore bytes until rx_valid & rx_sot, then treat that byte as DI.
- rx_sot=1 in any state aborts the current packet without pkt_done and restarts at DI with that byte.
- DI → WC0 → WC1 → ECC: latch each byte. The ECC byte compares {2'b00, ecc6(DI, WC)} against the received byte.
- On an ECC mismatch: hdr_valid=1 with ecc_err=1, no payload, no pkt_done, next state SYNC.
- On an ECC match of a short packet: hdr_valid=1 and pkt_done=1 in the same cycle, next state DI.
- On an ECC match of a long packet with WC > MAX_WC: hdr_valid=1, pkt_done=1 with len_err=1, next state SYNC.
- On an ECC match of a long packet with WC = 0: hdr_valid=1, next state CRC0.
- On an ECC match of any other long packet: hdr_valid=1, next state PAYLOAD.
- PAYLOAD: each byte is output with pl_valid and fed into the CRC. A 16-bit down-counter is loaded with WC. pl_last is asserted when the counter reaches 1, then next state CRC0.
- CRC0/CRC1: capture the CRC LSB, then the MSB. At CRC1: pkt_done=1, crc_err=(received ≠ computed), next state DI.
- Long/short classification: a packet is long iff DT ∈ {0x09,0x19,0x29,0x39,0x0C,0x0D,0x0E,0x1E,0x2E,0x3E}, else short.
- CRC: CRC-16, reflected polynomial 0x8408, initial value 0xFFFF, bytes processed LSB first, no final XOR. The CRC is re-initialised at every DI byte. An empty payload yields 0xFFFF.
- ECC: the standard DSI 6-bit Hamming parity over the 24 bits {WC_MSB, WC_LSB, DI}, with bit 0 = DI[0]. Detect only, no correction.

## Timing
- All outputs are registered, so each output appears 1 cycle after the rx byte that causes it.
- Every output resets to 0. State resets to SYNC, the CRC to 0xFFFF and the counter to 0.
- Strobe outputs (hdr_valid, pl_valid, pl_last, pkt_done) are 0 on any cycle whose previous cycle had rx_valid=0 or no event.
- Data outputs hold their last value between strobes.
- Gaps (rx_valid=0) are allowed anywhere and freeze all state.
- Packets may be back-to-back with zero idle cycles. A DI byte in the cycle after CRC1 is parsed normally.
- Reset asserted mid-packet clears all state immediately. Parsing resumes only on the next rx_sot.

## Structure
- Package dsi_pkt_pkg holds:
  - the state enum,
  - the long-DT list and an is_long_dt() function,
  - CRC_INIT=16'hFFFF and CRC_POLY=16'h8408,
  - a crc16_byte() function.
- Sub-module dsi_ecc_calc: combinational, 24-bit header in, 8-bit ECC out. The same unit is reusable by the transmitter.

## Test plan
- Short packet DI=0x01, WC=0x0000, ECC=0x07 → hdr_valid, hdr_long=0, ecc_err=0, pkt_done the same cycle, no pl_valid.
- Same packet with ECC=0x06 → ecc_err=1, no pkt_done. Following bytes are ignored until rx_sot.
- Long packet DI=0x39, WC=0x0009, ECC=0x30, payload "123456789" (0x31..0x39), CRC bytes 0x91,0x6F → 9 pl_valid beats, pl_last on 0x39, pkt_done with crc_err=0. With CRC byte 0x90 instead → crc_err=1.
- Long packet with WC=0 and CRC bytes 0xFF,0xFF → hdr_valid, no payload, pkt_done with crc_err=0. WC=MAX_WC+1 → pkt_done with len_err=1, then SYNC.
- Two back-to-back packets with random rx_valid gaps → identical outputs to the gap-free run. rx_sot mid-payload → restart with no pkt_done for the aborted packet.
- dsi_rst_n pulsed low mid-payload → all outputs 0 asynchronously, and the next packet is accepted only after rx_sot.
